// File: rtl/add_pkg.sv
// Shared types and elaboration helpers for the multi-cycle ripple adder.
package add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Slice index width; never narrower than one bit, even for a single slice.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

    function automatic bit chunk_cfg_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, the cell of the slice ripple.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/ripple_chunk.sv
// CHUNK-bit combinational ripple of full adders; cmsb is the carry into the top bit.
module ripple_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .x  (x[i]),
            .y  (y[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co   = c[CHUNK];
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/multicycle_ripple_adder.sv
// Multi-cycle ripple adder: one CHUNK-bit slice per clock through a single reused ripple_chunk.
// OVF_FLAG_EN adds the registered signed-overflow output ovf.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | adding slice idx, carry held in carry_q
// DONE  | result held on out_valid until out_ready
module multicycle_ripple_adder
    import add_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("multicycle_ripple_adder: WIDTH must be a multiple of CHUNK and CHUNK in 1..WIDTH");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              out_valid_q, out_valid_d;
`ifdef OVF_FLAG_EN
    logic              ovf_q, ovf_d;
`endif

    logic [31:0]       base;
    logic [CHUNK-1:0]  x_slice;
    logic [CHUNK-1:0]  y_slice;
    logic [CHUNK-1:0]  s_slice;
    logic              co_slice;
`ifdef OVF_FLAG_EN
    logic              cmsb_slice;
`else
    logic              cmsb_unused;
`endif

    always_comb begin
        base    = 32'(idx_q) * 32'(CHUNK);
        x_slice = a_q[base +: CHUNK];
        y_slice = b_q[base +: CHUNK];
    end

    ripple_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x    (x_slice),
        .y    (y_slice),
        .ci   (carry_q),
        .s    (s_slice),
        .co   (co_slice),
`ifdef OVF_FLAG_EN
        .cmsb (cmsb_slice)
`else
        .cmsb (cmsb_unused)
`endif
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
`ifdef OVF_FLAG_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[base +: CHUNK] = s_slice;
                carry_d              = co_slice;
                if (idx_q == IDX_LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    cout_d      = co_slice;
`ifdef OVF_FLAG_EN
                    ovf_d       = cmsb_slice ^ co_slice;
`endif
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef OVF_FLAG_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
`ifdef OVF_FLAG_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef OVF_FLAG_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_multicycle_ripple_adder.sv
// Bench for multicycle_ripple_adder: directed 8/4 vectors plus 32-bit streams at CHUNK 1, 4 and 32.
// Honours OVF_FLAG_EN for the ovf port.
module tb_multicycle_ripple_adder;

    localparam int NADD = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h (t=%0t)", nm, inst, act, exp, $time);
        end
    endtask

    function automatic int cfg_w(input int g);
        return (g == 0) ? 8 : 32;
    endfunction

    function automatic int cfg_c(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 4;
            default: return 32;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int W = cfg_w(g);
        localparam int C = cfg_c(g);
        localparam int N = W / C;

        logic         in_valid, in_ready, out_valid, out_ready, cin, cout;
        logic [W-1:0] a, b, sum;
`ifdef OVF_FLAG_EN
        logic         ovf;
`endif
        bit s_done = 1'b0;

        multicycle_ripple_adder #(.WIDTH(W), .CHUNK(C)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .cout      (cout)
`ifdef OVF_FLAG_EN
            ,
            .ovf       (ovf)
`endif
        );

        // Reference: plain (W+1)-bit addition; entry packs {ovf, cout, sum}.
        function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
            logic [W:0] full;
            logic       o;
            full = {1'b0, x} + {1'b0, y} + (W+1)'(c);
            o    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
            return {o, full};
        endfunction

        logic [W+1:0] expq[$];
        bit m_idle  = 1'b1;
        bit m_valid = 1'b0;
        bit m_fresh = 1'b1;
        int m_wait  = 0;

        // Transaction-level timing: busy N edges after acceptance, then valid until taken.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_idle  = 1'b1;
                m_valid = 1'b0;
                m_fresh = 1'b1;
                m_wait  = 0;
                expq.delete();
            end else if (m_valid) begin
                if (out_ready) begin
                    m_valid = 1'b0;
                    m_idle  = 1'b1;
                    void'(expq.pop_front());
                end
            end else if (m_idle) begin
                if (in_valid) begin
                    m_idle  = 1'b0;
                    m_fresh = 1'b0;
                    m_wait  = N;
                    expq.push_back(model(a, b, cin));
                end
            end else begin
                m_wait--;
                if (m_wait == 0) m_valid = 1'b1;
            end
        end

        always @(negedge clk) begin
            chk("in_ready", g, 64'(in_ready), 64'(m_idle));
            chk("out_valid", g, 64'(out_valid), 64'(m_valid));
            if (!rst_n || (m_fresh && m_idle)) begin
                chk("reset_sum", g, 64'(sum), 64'(0));
                chk("reset_cout", g, 64'(cout), 64'(0));
`ifdef OVF_FLAG_EN
                chk("reset_ovf", g, 64'(ovf), 64'(0));
`endif
            end
            if (m_valid && expq.size() > 0) begin
                chk("sum", g, 64'(sum), 64'(expq[0][W-1:0]));
                chk("cout", g, 64'(cout), 64'(expq[0][W]));
`ifdef OVF_FLAG_EN
                chk("ovf", g, 64'(ovf), 64'(expq[0][W+1]));
`endif
            end
        end

        if (g == 0) begin : g_dir
            // Called just after an edge with the DUT idle; returns with the result on out_valid.
            task automatic do_add(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                                  input logic [7:0] es, input logic ec, input logic eo, input string nm);
                int edges;
                a        = xa;
                b        = xb;
                cin      = xc;
                in_valid = 1'b1;
                @(posedge clk); #1;
                edges    = 1;
                in_valid = 1'b0;
                a        = ~xa;
                b        = 8'h5A;
                cin      = ~xc;
                while (!out_valid && edges < 20) begin
                    @(posedge clk); #1;
                    edges++;
                end
                chk({nm, "_latency"}, 0, 64'(edges), 64'(3));
                chk({nm, "_sum"}, 0, 64'(sum), 64'(es));
                chk({nm, "_cout"}, 0, 64'(cout), 64'(ec));
`ifdef OVF_FLAG_EN
                chk({nm, "_ovf"}, 0, 64'(ovf), 64'(eo));
`else
                if (eo !== eo) chk({nm, "_ovf_x"}, 0, 64'(eo), 64'(0));
`endif
            endtask

            task automatic take_result(input string nm);
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
                chk({nm, "_taken"}, 0, 64'(out_valid), 64'(0));
                chk({nm, "_ready_again"}, 0, 64'(in_ready), 64'(1));
            endtask

            initial begin
                rst_n     = 1'b1;
                in_valid  = 1'b0;
                out_ready = 1'b0;
                a         = '0;
                b         = '0;
                cin       = 1'b0;
                #1 rst_n  = 1'b0;
                #1;
                chk("por_in_ready", 0, 64'(in_ready), 64'(1));
                chk("por_out_valid", 0, 64'(out_valid), 64'(0));
                chk("por_sum", 0, 64'(sum), 64'(0));
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
                @(posedge clk); #1;

                do_add(8'h3C, 8'h55, 1'b0, 8'h91, 1'b0, 1'b1, "basic");
                take_result("basic");
                do_add(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "wrap");

                // Backpressure: result must survive ten stalled cycles and ignore new operands.
                for (int i = 0; i < 10; i++) begin
                    in_valid = (i % 2 == 0);
                    a        = 8'h11;
                    b        = 8'h22;
                    @(posedge clk); #1;
                    chk("bp_out_valid", 0, 64'(out_valid), 64'(1));
                    chk("bp_in_ready", 0, 64'(in_ready), 64'(0));
                    chk("bp_sum", 0, 64'(sum), 64'(8'h00));
                end
                in_valid = 1'b0;
                take_result("bp");
                do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "ovf");
                take_result("ovf");

                // Reset during the first RUN cycle drops the add.
                a        = 8'h3C;
                b        = 8'h55;
                cin      = 1'b0;
                in_valid = 1'b1;
                @(posedge clk); #1;
                in_valid = 1'b0;
                chk("midrun_busy", 0, 64'(in_ready), 64'(0));
                rst_n = 1'b0;
                #1;
                chk("midrun_out_valid", 0, 64'(out_valid), 64'(0));
                chk("midrun_sum", 0, 64'(sum), 64'(0));
                chk("midrun_in_ready", 0, 64'(in_ready), 64'(1));
                @(posedge clk); #1;
                rst_n = 1'b1;
                repeat (4) @(posedge clk);
                #1;
                chk("midrun_no_result", 0, 64'(out_valid), 64'(0));
                do_add(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "post_rst");
                take_result("post_rst");
                s_done = 1'b1;
            end
        end else begin : g_stream
            initial begin
                int n_acc;
                int last;
                in_valid  = 1'b0;
                out_ready = 1'b1;
                a         = '0;
                b         = '0;
                cin       = 1'b0;
                wait (g_cfg[0].s_done);
                @(posedge clk); #1;
                in_valid = 1'b1;
                n_acc    = 0;
                last     = -1;
                for (int t = 0; t < NADD * (N + 2) + 50 && n_acc < NADD; t++) begin
                    a   = W'($urandom);
                    b   = W'($urandom);
                    cin = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (in_ready) begin
                        if (last >= 0) chk("throughput", g, 64'(cyc - last), 64'(N + 2));
                        last = cyc;
                        n_acc++;
                    end
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
                chk("stream_count", g, 64'(n_acc), 64'(NADD));
                repeat (N + 4) @(posedge clk);
                s_done = 1'b1;
            end
        end
    end

    initial begin
        bit all_done;
        all_done = 1'b0;
        while (!all_done && cyc < 90000) begin
            @(posedge clk);
            all_done = g_cfg[0].s_done && g_cfg[1].s_done && g_cfg[2].s_done && g_cfg[3].s_done;
        end
        chk("all_done", 0, 64'(all_done), 64'(1));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
